// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants, state encoding and helpers for the VGA
//                640x480 block-colour output stage.
//                  COLS / ROWS   - block grid (64 x 48, 10x10-pixel blocks)
//                  ADDR_W        - frame-buffer address width
//                  FB_WORDS      - number of frame-buffer words (3072)
//                  COLOUR_W      - colour width, {R,G,B}
//                  BLACK         - all-off colour
//                  state_e       - CLEAR / RUN
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int COLS     = 64;
  localparam int ROWS     = 48;
  localparam int ADDR_W   = 12;
  localparam int COLOUR_W = 3;

  localparam logic [ADDR_W-1:0]   FB_WORDS  = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COLOUR_W-1:0] BLACK     = '0;

  // Last visible block row; anything above is treated as blank.
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // COLS is a power of two, so row*COLS + col is a plain concatenation.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [5:0] row,
                                                input logic [5:0] col);
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_out_if
//  Description : Frame-buffer write port between a pixel writer (master) and
//                the VGA output stage (slave).
//                  wr_en    - write request (held until acknowledged)
//                  wr_addr  - block address, row*64 + column
//                  wr_data  - {R,G,B} colour
//                  wr_ready - request accepted this cycle when wr_en=1
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_out_if
  import vga_pkg::*;
  ();

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic                wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/vga_framebuf.sv
`default_nettype none
// ============================================================================
//  Module      : vga_framebuf
//  Description : DEPTH x DATA_W synchronous RAM, one write port and one read
//                port. Read data is registered (1-cycle latency); a read and
//                write to the same address in one cycle returns the old word.
//  Ports       : clk      - clock
//                we       - write enable
//                waddr    - write address
//                wdata    - write data
//                raddr    - read address (out-of-range reads return 0)
//                rdata    - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_framebuf #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 3
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Callers only write legal addresses; the guard keeps stray ones harmless.
  always_ff @(posedge clk) begin
    if (we && (waddr < LIMIT)) begin
      mem[waddr] <= wdata;
    end
  end

  // Rows beyond the array are blanked downstream; return 0 for them anyway.
  always_ff @(posedge clk) begin
    if (raddr < LIMIT) begin
      rdata_q <= mem[raddr];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_out
//  Description : Final colour stage of the VGA 640x480 pipeline. Looks each
//                10x10-pixel block up in a 64x48x3 frame buffer (or shows a
//                colour-bar pattern), drives the colour pins and delays the
//                syncs so that everything lines up 2 clocks after the inputs.
//                After reset the buffer is cleared (3072 cycles) before
//                normal operation; writes are accepted only in vertical blank.
//  Ports       : clk, reset        - clock, synchronous active-low reset
//                vpixel, vdeactivate - block row and vertical-blank flag
//                hpixel, hdeactivate - block column and horizontal-blank flag
//                hsync_in, vsync_in  - raw syncs
//                pattern_sel         - 1 = colour bars, 0 = frame buffer
//                wr                  - frame-buffer write port (slave)
//                VGA_RED/GREEN/BLUE  - colour pins
//                VGA_HSYNC/VSYNC     - syncs aligned with colour
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_out
  import vga_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic [5:0]   vpixel,
  input  wire logic         vdeactivate,
  input  wire logic [6:0]   hpixel,
  input  wire logic         hdeactivate,
  input  wire logic         hsync_in,
  input  wire logic         vsync_in,
  input  wire logic         pattern_sel,
  vga_pixel_out_if.slave    wr,
  output logic              VGA_RED,
  output logic              VGA_GREEN,
  output logic              VGA_BLUE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC
);

  // --------------------------------------------------------------------------
  // Control FSM and frame-buffer write mux
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clear_cnt_q, clear_cnt_d;

  logic                fb_we;
  logic [ADDR_W-1:0]   fb_waddr;
  logic [COLOUR_W-1:0] fb_wdata;
  logic [ADDR_W-1:0]   fb_raddr;
  logic [COLOUR_W-1:0] fb_rdata;
  logic                ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    fb_we       = 1'b0;
    fb_waddr    = clear_cnt_q;
    fb_wdata    = BLACK;
    ready       = 1'b0;

    case (state_q)
      CLEAR: begin
        fb_we       = 1'b1;
        clear_cnt_d = clear_cnt_q + 12'd1;
        if (clear_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          clear_cnt_d = '0;
        end
      end
      RUN: begin
        ready    = vdeactivate;
        fb_waddr = wr.wr_addr;
        fb_wdata = wr.wr_data;
        // Out-of-range addresses are acknowledged but never stored.
        fb_we    = wr.wr_en & vdeactivate & (wr.wr_addr < FB_WORDS);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // A request seen while reset is held must neither commit nor be acked,
    // otherwise the requester would drop a write that never happened.
    if (!reset) begin
      fb_we = 1'b0;
      ready = 1'b0;
    end
  end

  assign wr.wr_ready = ready;

  // Read address is formed combinationally; the RAM's registered read makes
  // it the stage-1 register of the pixel pipeline.
  assign fb_raddr = fb_addr(vpixel, hpixel[5:0]);

  vga_framebuf #(
    .DEPTH  (COLS * ROWS),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOUR_W)
  ) u_framebuf (
    .clk   (clk),
    .we    (fb_we),
    .waddr (fb_waddr),
    .wdata (fb_wdata),
    .raddr (fb_raddr),
    .rdata (fb_rdata)
  );

  // --------------------------------------------------------------------------
  // Stage 1: blank decode, pattern data, sync delay
  // --------------------------------------------------------------------------
  logic       valid1_q, valid1_d;
  logic       blank1_q, blank1_d;
  logic       pat1_q,   pat1_d;
  logic [2:0] bar1_q,   bar1_d;
  logic       hsync1_q, hsync1_d;
  logic       vsync1_q, vsync1_d;

  always_comb begin
    valid1_d = (state_q == RUN);
    blank1_d = vdeactivate | hdeactivate | (vpixel > LAST_ROW) | hpixel[6];
    pat1_d   = pattern_sel;
    bar1_d   = hpixel[5:3];
    hsync1_d = hsync_in;
    vsync1_d = vsync_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid1_q <= 1'b0;
      blank1_q <= 1'b1;
      pat1_q   <= 1'b0;
      bar1_q   <= '0;
      hsync1_q <= 1'b0;
      vsync1_q <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
      blank1_q <= blank1_d;
      pat1_q   <= pat1_d;
      bar1_q   <= bar1_d;
      hsync1_q <= hsync1_d;
      vsync1_q <= vsync1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: colour select and output registers
  // --------------------------------------------------------------------------
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                hsync2_q, hsync2_d;
  logic                vsync2_q, vsync2_d;

  always_comb begin
    colour_d = BLACK;
    if (valid1_q && !blank1_q) begin
      colour_d = pat1_q ? bar1_q : fb_rdata;
    end
    hsync2_d = hsync1_q;
    vsync2_d = vsync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      colour_q <= BLACK;
      hsync2_q <= 1'b0;
      vsync2_q <= 1'b0;
    end else begin
      colour_q <= colour_d;
      hsync2_q <= hsync2_d;
      vsync2_q <= vsync2_d;
    end
  end

  assign VGA_RED   = colour_q[2];
  assign VGA_GREEN = colour_q[1];
  assign VGA_BLUE  = colour_q[0];
  assign VGA_HSYNC = hsync2_q;
  assign VGA_VSYNC = vsync2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_out
//  Description : Self-checking bench for vga_pixel_out. Each cycle the
//                expected pin values are computed from a reference model and
//                queued; they are compared two clocks later when the DUT
//                presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_out;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] vpixel;
  logic       vdeactivate;
  logic [6:0] hpixel;
  logic       hdeactivate;
  logic       hsync_in;
  logic       vsync_in;
  logic       pattern_sel;
  logic       VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

  vga_pixel_out_if wr_if ();

  always #5 clk = ~clk;

  vga_pixel_out dut (
    .clk         (clk),
    .reset       (reset),
    .vpixel      (vpixel),
    .vdeactivate (vdeactivate),
    .hpixel      (hpixel),
    .hdeactivate (hdeactivate),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pattern_sel (pattern_sel),
    .wr          (wr_if),
    .VGA_RED     (VGA_RED),
    .VGA_GREEN   (VGA_GREEN),
    .VGA_BLUE    (VGA_BLUE),
    .VGA_HSYNC   (VGA_HSYNC),
    .VGA_VSYNC   (VGA_VSYNC)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  // Reference model state
  logic [2:0] model_mem [3072];
  bit         model_run = 1'b0;
  int         model_clr = 0;
  logic [4:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] pins();
    return {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC};
  endfunction

  // Expected {R,G,B,HS,VS} two clocks after the current inputs.
  function automatic logic [4:0] model_pins();
    logic [2:0] c;
    logic       blank;
    int         a;
    c     = 3'b000;
    blank = vdeactivate | hdeactivate | (vpixel > 6'd47) | (hpixel > 7'd63);
    a     = int'(vpixel) * 64 + int'(hpixel[5:0]);
    if (model_run && !blank) begin
      c = pattern_sel ? hpixel[5:3] : model_mem[a];
    end
    return {c, hsync_in, vsync_in};
  endfunction

  // One clock of stimulus: queue expectation, update model, advance, compare.
  task automatic tick();
    if (!reset) begin
      @(posedge clk);
      #1;
      exp_q.delete();
      exp_q.push_back(5'b00000);
      model_run = 1'b0;
      model_clr = 0;
      chk({phase, "_rst_pins"}, 32'(pins()), 32'h0);
      return;
    end
    #1;
    chk({phase, "_ready"}, 32'(wr_if.wr_ready), 32'(model_run & vdeactivate));
    exp_q.push_back(model_pins());
    if (!model_run) begin
      model_mem[model_clr] = 3'b000;
      if (model_clr == 3071) model_run = 1'b1;
      model_clr++;
    end else if (wr_if.wr_en && vdeactivate && (wr_if.wr_addr < 12'd3072)) begin
      model_mem[int'(wr_if.wr_addr)] = wr_if.wr_data;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      chk({phase, "_pins"}, 32'(pins()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic set_px(input int v, input int h, input bit vd, input bit hd, input bit pat);
    vpixel      = 6'(v);
    hpixel      = 7'(h);
    vdeactivate = vd;
    hdeactivate = hd;
    pattern_sel = pat;
  endtask

  task automatic set_wr(input bit en, input int addr, input int data);
    wr_if.wr_en   = en;
    wr_if.wr_addr = 12'(addr);
    wr_if.wr_data = 3'(data);
  endtask

  task automatic random_syncs();
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_phase(input string name);
    phase = name;
    for (int i = 0; i < 3072; i++) begin
      set_px($urandom_range(0, 63), $urandom_range(0, 127),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_wr(1'($urandom_range(0, 1)), $urandom_range(0, 4095), $urandom_range(1, 7));
      random_syncs();
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) model_mem[i] = 3'bxxx;
    reset = 1'b0;
    set_px(0, 0, 1'b0, 1'b0, 1'b0);
    set_wr(1'b0, 0, 0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // Reset held for 5 cycles
    phase = "reset";
    for (int i = 0; i < 5; i++) begin
      random_syncs();
      tick();
    end
    reset = 1'b1;

    // Power-up clear: pins black, no acks, syncs pass through
    clear_phase("clear");
    chk("run_entered", 32'(model_run), 32'h1);

    // First RUN reads of (0,0) return black
    phase = "first_read";
    set_wr(1'b0, 0, 0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    set_px(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();

    // Write 130 = 3'b101 during vertical blank, plus a discarded high address
    phase = "wr130";
    set_px(40, 5, 1'b1, 1'b0, 1'b0);
    set_wr(1'b1, 130, 3'b101);
    tick();
    set_wr(1'b1, 3100, 3'b111);
    tick();
    set_wr(1'b0, 0, 0);

    phase = "rd130";
    set_px(2, 2, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Write attempt during active video must be refused
    phase = "wr_active";
    set_px(1, 1, 1'b0, 1'b0, 1'b0);
    set_wr(1'b1, 0, 3'b111);
    tick();
    set_wr(1'b0, 0, 0);
    phase = "rd0";
    set_px(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Colour bars on row 10, with random horizontal blanking
    phase = "bars";
    for (int h = 0; h < 64; h++) begin
      set_px(10, h, 1'b0, ($urandom_range(0, 3) == 0), 1'b1);
      random_syncs();
      tick();
    end

    // Out-of-range rows / columns are blank
    phase = "oob";
    set_px(50, 10, 1'b0, 1'b0, 1'b1);
    tick();
    set_px(3, 100, 1'b0, 1'b0, 1'b1);
    tick();
    set_px(63, 127, 1'b0, 1'b0, 1'b0);
    tick();

    // Random mix of blank-time writes and active reads over a small region
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      set_px($urandom_range(0, 3), $urandom_range(0, 7),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 4) == 0));
      set_wr(1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? $urandom_range(3072, 4095)
                                         : ($urandom_range(0, 3) * 64 + $urandom_range(0, 7)),
             $urandom_range(0, 7));
      random_syncs();
      tick();
    end

    // Write 500 = 3'b010 and read it back at (7,52)
    phase = "wr500";
    set_px(0, 0, 1'b1, 1'b1, 1'b0);
    set_wr(1'b1, 500, 3'b010);
    tick();
    set_wr(1'b0, 0, 0);
    phase = "rd500";
    set_px(7, 52, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Mid-frame reset with a pending write request
    phase = "midreset";
    reset = 1'b0;
    set_px(7, 52, 1'b1, 1'b0, 1'b0);
    set_wr(1'b1, 500, 3'b110);
    repeat (2) tick();
    reset = 1'b1;
    clear_phase("reclear");

    phase = "rd500_after";
    set_wr(1'b0, 0, 0);
    set_px(7, 52, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    set_px(2, 2, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
